// File: rtl/sw_pe.sv
// Smith-Waterman systolic processing element: one query char, linear gap.
// Optional SW_MAXPOS_EN tracks the column of this PE's best score.
module sw_pe #(
    parameter int CHAR_W   = 2,
    parameter int SCORE_W  = 16,
    parameter int MATCH    = 2,
    parameter int MISMATCH = 1,
    parameter int GAP      = 1,
    parameter int POS_W    = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               q_load,
    input  logic [CHAR_W-1:0]  q_char,
    input  logic               in_valid,
    input  logic               in_sos,
    input  logic [CHAR_W-1:0]  in_char,
    input  logic [SCORE_W-1:0] in_h,
    input  logic [SCORE_W-1:0] in_max,
    output logic               out_valid,
    output logic               out_sos,
    output logic [CHAR_W-1:0]  out_char,
    output logic [SCORE_W-1:0] out_h,
    output logic [SCORE_W-1:0] out_max,
    output logic               q_loaded,
    output logic [POS_W-1:0]   pe_max_pos
);

    localparam int EW = SCORE_W + 2;
    localparam logic signed [EW-1:0] SAT = {2'b00, {SCORE_W{1'b1}}};

    logic [CHAR_W-1:0]  q;
    logic [SCORE_W-1:0] h_self;
    logic [SCORE_W-1:0] h_diag;
    logic [SCORE_W-1:0] pe_max;

    logic [SCORE_W-1:0] diag;
    logic [SCORE_W-1:0] up;
    logic [SCORE_W-1:0] pe_max_eff;
    logic signed [EW-1:0] diag_x;
    logic signed [EW-1:0] up_x;
    logic signed [EW-1:0] left_x;
    logic signed [EW-1:0] s_x;
    logic signed [EW-1:0] t_d;
    logic signed [EW-1:0] t_u;
    logic signed [EW-1:0] t_l;
    logic signed [EW-1:0] best;
    logic [SCORE_W-1:0] h_new;
    logic [SCORE_W-1:0] pe_max_new;
    logic [SCORE_W-1:0] max_new;

    // Signed headroom keeps negative candidates and overflow visible before clamping.
    always_comb begin
        diag       = in_sos ? '0 : h_diag;
        up         = in_sos ? '0 : h_self;
        pe_max_eff = in_sos ? '0 : pe_max;
        diag_x     = {2'b00, diag};
        up_x       = {2'b00, up};
        left_x     = {2'b00, in_h};
        s_x        = (q == in_char) ? EW'(MATCH) : EW'(-MISMATCH);
        t_d        = diag_x + s_x;
        t_u        = up_x - EW'(GAP);
        t_l        = left_x - EW'(GAP);
        best       = '0;
        if (t_d > best) best = t_d;
        if (t_u > best) best = t_u;
        if (t_l > best) best = t_l;
        if (best > SAT) best = SAT;
        h_new      = best[SCORE_W-1:0];
        pe_max_new = (pe_max_eff > h_new) ? pe_max_eff : h_new;
        max_new    = (in_max > pe_max_new) ? in_max : pe_max_new;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q         <= '0;
            q_loaded  <= 1'b0;
            h_self    <= '0;
            h_diag    <= '0;
            pe_max    <= '0;
            out_valid <= 1'b0;
            out_sos   <= 1'b0;
            out_char  <= '0;
            out_h     <= '0;
            out_max   <= '0;
        end else begin
            if (q_load) begin
                q        <= q_char;
                q_loaded <= 1'b1;
            end
            out_valid <= in_valid;
            if (in_valid) begin
                out_sos  <= in_sos;
                out_char <= in_char;
                if (q_loaded) begin
                    h_self  <= h_new;
                    h_diag  <= in_h;
                    pe_max  <= pe_max_new;
                    out_h   <= h_new;
                    out_max <= max_new;
                end else begin
                    out_h   <= '0;
                    out_max <= in_max;
                end
            end
        end
    end

`ifdef SW_MAXPOS_EN
    logic [POS_W-1:0] col;
    logic [POS_W-1:0] col_eff;
    logic [POS_W-1:0] max_pos;

    // col holds the index the next non-sos beat will take.
    assign col_eff    = in_sos ? '0 : col;
    assign pe_max_pos = max_pos;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col     <= '0;
            max_pos <= '0;
        end else if (in_valid) begin
            col <= col_eff + POS_W'(1);
            if (q_loaded && h_new > pe_max_eff) begin
                max_pos <= col_eff;
            end else if (in_sos) begin
                max_pos <= '0;
            end
        end
    end
`else
    assign pe_max_pos = '0;
`endif

endmodule
